// File: rtl/cond_unit.sv
// Conditional-execution unit: evaluates the instruction condition against the
// stored NZCV flags and gates the decoder write requests. It also keeps the
// flag register and saturating executed/squashed instruction counters.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    logic [3:0]       flags_reg;
    logic [CNT_W-1:0] exec_reg;
    logic [CNT_W-1:0] skip_reg;
    logic             cond_ex;
    logic             n_f, z_f, c_f, v_f;
    logic             take;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        if (&x) begin
            return x;
        end
        return x + CNT_W'(1);
    endfunction

    assign {n_f, z_f, c_f, v_f} = flags_reg;

    // Condition decode against the stored flags (never the in-flight ALUFlags).
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Writes are only let through for a valid, passing instruction outside reset.
    assign take     = en & cond_ex & ~reset;
    assign PCSrc    = PCS & take;
    assign RegWrite = RegW & ~NoWrite & take;
    assign MemWrite = MemW & take;
    assign CondEx   = cond_ex;

    assign Flags     = flags_reg;
    assign ExecCount = exec_reg;
    assign SkipCount = skip_reg;

    // Flag register: NZ and CV halves load independently, only for passing instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg <= 4'b0000;
        end else if (en && cond_ex) begin
            if (FlagW[1]) begin
                flags_reg[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                flags_reg[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Executed / squashed instruction counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_reg <= '0;
            skip_reg <= '0;
        end else if (en) begin
            if (cond_ex) begin
                exec_reg <= sat_inc(exec_reg);
            end else begin
                skip_reg <= sat_inc(skip_reg);
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: the driver predicts each cycle's outputs
// from a behavioural model and queues them; a monitor compares at negedge.
module tb_cond_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, en;
    logic [3:0]       Cond, ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW, NoWrite;
    logic             PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCount, SkipCount;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .Flags(Flags), .ExecCount(ExecCount), .SkipCount(SkipCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic       condex;
        logic [3:0] flags;
        int         exec;
        int         skip;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state
    logic [3:0] m_flags;
    int         m_exec, m_skip;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Condition pass/fail from the mnemonic table: even codes are the base test,
    // odd codes its negation; 111x are always / never.
    function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (cond == 4'b1110);
        endcase
        return cond[0] ? !base : base;
    endfunction

    function automatic int sat(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    task automatic drive(input logic rst, input logic e, input logic [3:0] cond,
                         input logic [3:0] af, input logic [1:0] fw,
                         input logic pcs, input logic rw, input logic mw, input logic nw);
        exp_t x;
        logic ce;
        @(posedge clk); #1;
        reset = rst; en = e; Cond = cond; ALUFlags = af; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        ce = model_cond(cond, m_flags);
        x.condex   = ce;
        x.pcsrc    = pcs && ce && e && !rst;
        x.regwrite = rw && !nw && ce && e && !rst;
        x.memwrite = mw && ce && e && !rst;
        x.flags    = m_flags;
        x.exec     = m_exec;
        x.skip     = m_skip;
        q.push_back(x);
        if (rst) begin
            m_flags = 4'b0000; m_exec = 0; m_skip = 0;
        end else if (e) begin
            if (ce) begin
                if (fw[1]) m_flags[3:2] = af[3:2];
                if (fw[0]) m_flags[1:0] = af[1:0];
                m_exec = sat(m_exec);
            end else begin
                m_skip = sat(m_skip);
            end
        end
    endtask

    // Monitor: compare every predicted cycle away from the active edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("CondEx",    int'(CondEx),    int'(x.condex));
                chk("PCSrc",     int'(PCSrc),     int'(x.pcsrc));
                chk("RegWrite",  int'(RegWrite),  int'(x.regwrite));
                chk("MemWrite",  int'(MemWrite),  int'(x.memwrite));
                chk("Flags",     int'(Flags),     int'(x.flags));
                chk("ExecCount", int'(ExecCount), x.exec);
                chk("SkipCount", int'(SkipCount), x.skip);
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        m_flags = 4'b0000; m_exec = 0; m_skip = 0;
        // Initial reset cycle: DUT state is unknown before it, so nothing is predicted.
        @(posedge clk); #1;

        // Reset held with a passing instruction: write enables forced low.
        drive(1, 1, 4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0);
        // Post-reset: EQ fails, NE passes, AL passes (en low, no state change).
        drive(0, 0, 4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0);
        drive(0, 0, 4'b0001, 4'b0000, 2'b00, 1, 1, 1, 0);
        drive(0, 0, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0);
        // AL register write, counts one executed instruction.
        drive(0, 1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0);
        // Flag set to Z, then EQ memory write sees it next cycle.
        drive(0, 1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0);
        drive(0, 1, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0);
        // NE branch squashed: no PC write, flags unchanged, skip count up.
        drive(0, 1, 4'b0001, 4'b1011, 2'b11, 1, 0, 0, 0);
        // Compare-class: register write suppressed, flags updated.
        drive(0, 1, 4'b1110, 4'b1001, 2'b11, 0, 1, 0, 1);
        // Split flag-write halves.
        drive(0, 1, 4'b1110, 4'b0110, 2'b10, 0, 0, 0, 0);
        drive(0, 1, 4'b1110, 4'b1111, 2'b01, 0, 0, 0, 0);
        drive(0, 0, 4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0);

        // Full condition table: load each flag value, then sweep all conditions with en low.
        for (int f = 0; f < 16; f++) begin
            drive(0, 1, 4'b1110, 4'(f), 2'b11, 0, 0, 0, 0);
            for (int c = 0; c < 16; c++)
                drive(0, 0, 4'(c), 4'(~f), 2'b11, 1, 1, 1, 0);
        end

        // Counter saturation.
        drive(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            drive(0, 1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0);
        drive(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        chk("ExecSaturated", int'(ExecCount), 15);
        for (int i = 0; i < 20; i++)
            drive(0, 1, 4'b1111, 4'b0000, 2'b00, 0, 1, 0, 0);
        // Reset wins over en.
        drive(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
        drive(0, 0, 4'b0001, 4'b0000, 2'b00, 1, 1, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                  4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 entries left", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter: CNT_W, default 16, width of the executed and squashed instruction counters.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  instruction valid this cycle; when low, no state updates and all write-enable outputs are 0.
REQ-005 Cond  input  4  instruction condition field (bits 31:28).
REQ-006 ALUFlags  input  4  ALU result flags {N,Z,C,V} for the current instruction.
REQ-007 FlagW  input  2  decoder flag-write request; [1] covers N,Z and [0] covers C,V.
REQ-008 PCS  input  1  decoder PC-write request (branch or Rd=R15).
REQ-009 RegW  input  1  decoder register-write request.
REQ-010 MemW  input  1  decoder memory-write request.
REQ-011 NoWrite  input  1  decoder compare-class indication; suppresses the register write.
REQ-012 PCSrc  output  1  gated PC write.
REQ-013 RegWrite  output  1  gated register-file write.
REQ-014 MemWrite  output  1  gated data-memory write.
REQ-015 CondEx  output  1  the condition passes against the stored flags.
REQ-016 Flags  output  4  stored {N,Z,C,V}.
REQ-017 ExecCount  output  CNT_W  count of executed instructions.
REQ-018 SkipCount  output  CNT_W  count of squashed instructions.

Function
REQ-019 CondEx SHALL be combinational from Cond and the stored Flags (not ALUFlags), using this table:
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
- 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
- 1000 HI C&!Z; 1001 LS !C|Z.
- 1010 GE N==V; 1011 LT N!=V.
- 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
- 1110 AL 1; 1111 0.
REQ-020 PCSrc SHALL equal PCS&CondEx&en.
REQ-021 RegWrite SHALL equal RegW&!NoWrite&CondEx&en.
REQ-022 MemWrite SHALL equal MemW&CondEx&en.
REQ-023 On a clock edge with en&CondEx&FlagW[1], Flags[3:2] SHALL load ALUFlags[3:2]; otherwise Flags[3:2] hold.
REQ-024 On a clock edge with en&CondEx&FlagW[0], Flags[1:0] SHALL load ALUFlags[1:0]; otherwise Flags[1:0] hold.
REQ-025 A flag update SHALL become visible to CondEx in the following cycle (1-cycle latency); the current instruction always evaluates against the pre-update flags.
REQ-026 On an edge with en&CondEx, ExecCount SHALL increment by 1.
REQ-027 On an edge with en&!CondEx, SkipCount SHALL increment by 1.
REQ-028 Both counters SHALL saturate at all-ones and never wrap.
REQ-029 When en=0, Flags and both counters SHALL hold, and PCSrc, RegWrite and MemWrite SHALL be 0; CondEx is still driven.
REQ-030 A squashed instruction SHALL NOT update flags, even if FlagW is nonzero.

Reset
REQ-031 When reset=1 at a clock edge, Flags SHALL go to 0000 and ExecCount and SkipCount to 0; reset takes priority over en.
REQ-032 While reset is high, PCSrc, RegWrite and MemWrite SHALL be forced to 0.
REQ-033 Immediately after reset, with Flags=0000: EQ fails, NE passes, AL passes.

Verification
REQ-034 Reset, then Cond=1110, RegW=1, en=1 -> RegWrite=1, CondEx=1; ExecCount=1 next cycle.
REQ-035 Cycle 1: Cond=1110, FlagW=11, ALUFlags=0100. Cycle 2: Cond=0000, MemW=1. -> Flags=0100 after cycle 1; MemWrite=1 in cycle 2.
REQ-036 Flags=0100, Cond=0001, PCS=1, FlagW=11, ALUFlags=1011 -> PCSrc=0; Flags stay 0100; SkipCount increments.
REQ-037 Cond=1110, RegW=1, NoWrite=1, FlagW=11, ALUFlags=1001 -> RegWrite=0; Flags=1001 next cycle.
REQ-038 Step all 16 Cond values for each of the 16 Flags values -> CondEx matches the REQ-019 table in all 256 cases.
REQ-039 With CNT_W=4, run 20 always-pass instructions -> ExecCount holds at 15. Then assert reset with en=1 -> both counters 0 and Flags 0000 on the next cycle.
